// File: rtl/axi_lite_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_sram_slave
// AXI4-Lite subordinate in front of a word-organised on-chip SRAM. The read and
// write channels each have their own small FSM. Each FSM adds a programmable
// number of wait cycles before it answers, so that requester handshake logic
// is exercised under delay. Data is always a full 32-bit word. The requester
// does any byte-lane shifting and sign extension.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words. Valid when addr[31:2] < DEPTH_WORDS.
//   RD_LAT      : extra wait cycles from the AR handshake to rvalid (0..15).
//   WR_LAT      : extra wait cycles from the later of the AW/W handshakes to
//                 bvalid (0..15).
//
// Ports
//   clk, rst               : clock (rising edge); synchronous active-high reset
//   araddr/arvalid/arready : read address channel
//   rdata/rresp/rvalid/rready : read data channel (00 OKAY, 10 SLVERR)
//   awaddr/awvalid/awready : write address channel
//   wdata/wstrb/wvalid/wready : write data channel, wstrb[i] -> wdata[8i+7:8i]
//   bresp/bvalid/bready    : write response channel
// -----------------------------------------------------------------------------
module axi_lite_sram_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 2,
  parameter int WR_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // Memory is intentionally not reset; contents are undefined at power-up.
  logic [31:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [29:0] ar_word;
  logic [29:0] r_word;
  logic        r_in_range;
  logic        r_sample;

  assign arready = (r_state == R_IDLE);

  // With zero latency the sample happens on the AR handshake edge itself.
  // In that case the live address is used instead of the captured one.
  always_comb begin
    r_word     = (r_state == R_IDLE) ? araddr[31:2] : ar_word;
    r_in_range = ({2'b00, r_word} < 32'(DEPTH_WORDS));
    r_sample   = 1'b0;
    if (r_state == R_IDLE) begin
      r_sample = arvalid && (RD_LAT == 0);
    end else if (r_state == R_WAIT) begin
      r_sample = (r_cnt == 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_cnt   <= 4'd0;
      ar_word <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      // rdata/rresp are only updated on entry to R_RESP.
      // This keeps them stable while rvalid waits for rready.
      if (r_sample) begin
        rvalid <= 1'b1;
        if (r_in_range) begin
          rdata <= mem[r_word[IDX_W-1:0]];
          rresp <= RESP_OKAY;
        end else begin
          rdata <= '0;
          rresp <= RESP_SLVERR;
        end
      end
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            ar_word <= araddr[31:2];
            if (RD_LAT == 0) begin
              r_state <= R_RESP;
            end else begin
              r_cnt   <= 4'(RD_LAT);
              r_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= R_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  logic [1:0]  w_state;
  logic [3:0]  w_cnt;
  logic        aw_done;
  logic        w_done;
  logic [29:0] aw_word;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_fire;
  logic        w_fire;
  logic        aw_have;
  logic        w_have;
  logic [29:0] c_word;
  logic [31:0] c_data;
  logic [3:0]  c_strb;
  logic        w_in_range;
  logic        w_commit;

  // Each ready drops as soon as its own beat has been captured.
  // The other channel can still be waiting at that point.
  assign awready = (w_state == W_IDLE) && !aw_done;
  assign wready  = (w_state == W_IDLE) && !w_done;

  // The captured flags stay set until the B handshake.
  // That lets the commit path choose between the live and captured values.
  always_comb begin
    aw_fire    = awvalid && awready;
    w_fire     = wvalid && wready;
    aw_have    = aw_done || aw_fire;
    w_have     = w_done || w_fire;
    c_word     = aw_done ? aw_word : awaddr[31:2];
    c_data     = w_done ? w_data_q : wdata;
    c_strb     = w_done ? w_strb_q : wstrb;
    w_in_range = ({2'b00, c_word} < 32'(DEPTH_WORDS));
    w_commit   = 1'b0;
    if (w_state == W_IDLE) begin
      w_commit = aw_have && w_have && (WR_LAT == 0);
    end else if (w_state == W_WAIT) begin
      w_commit = (w_cnt == 4'd1);
    end
  end

  // The commit shares the edge on which bvalid rises.
  // A reset on that edge suppresses it.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (c_strb[i]) begin
          mem[c_word[IDX_W-1:0]][8*i +: 8] <= c_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state  <= W_IDLE;
      w_cnt    <= 4'd0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      aw_word  <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      if (w_commit) begin
        bvalid <= 1'b1;
        bresp  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            aw_done <= 1'b1;
            aw_word <= awaddr[31:2];
          end
          if (w_fire) begin
            w_done   <= 1'b1;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
          end
          if (aw_have && w_have) begin
            if (WR_LAT == 0) begin
              w_state <= W_RESP;
            end else begin
              w_cnt   <= 4'(WR_LAT);
              w_state <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          if (w_cnt == 4'd1) begin
            w_cnt   <= 4'd0;
            w_state <= W_RESP;
          end else begin
            w_cnt <= w_cnt - 4'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-offset bits carry no meaning for a word-organised memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{araddr[1:0], awaddr[1:0]};

endmodule
